// File: rtl/chnl_pkg.sv
// Shared definitions for the RIFFA RX channel to stream bridge.
package chnl_pkg;

  // Receive FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_RECV  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // 32-bit words per beat at the default 32-bit channel width
  localparam int W = 1;

  // Number of 32-bit words carried by one beat of a dw-bit channel
  function automatic int words_per_beat(input int dw);
    return dw / 32;
  endfunction

endpackage

// File: rtl/chnl_sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty flags.
module chnl_sync_fifo #(
  parameter int WIDTH      = 33,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push, do_pop;

  // Push into a full FIFO and pop from an empty one are dropped
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  // Head is forced to zero while empty so the outputs are clean after reset
  assign dout    = empty ? '0 : mem[rptr];

  // Storage write; contents need no reset since empty masks the head
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers wrap naturally; occupancy tracks push/pop balance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/chnl_rx_stream.sv
// RIFFA RX channel consumer: accepts one transaction at a time, buffers the
// payload in a FWFT FIFO and presents it as a valid/ready stream with a
// final-beat flag.
module chnl_rx_stream
  import chnl_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH  = 32,
  parameter int C_FIFO_DEPTH_LOG2 = 4
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  output logic                        CHNL_RX_CLK,
  input  logic                        CHNL_RX,
  output logic                        CHNL_RX_ACK,
  input  logic                        CHNL_RX_LAST,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [30:0]                 CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_DATA_REN,
  output logic [C_PCI_DATA_WIDTH-1:0] STRM_DATA,
  output logic                        STRM_VALID,
  input  logic                        STRM_READY,
  output logic                        STRM_LAST,
  output logic [31:0]                 XFER_LEN,
  output logic                        BUSY
);

  localparam int DW  = C_PCI_DATA_WIDTH;
  localparam int WPB = words_per_beat(DW);
  localparam logic [32:0] WPB33 = 33'(WPB);

  state_t      state;
  logic [31:0] r_len, r_count;
  logic        r_last_txn;
  logic        ack, busy;
  logic        push, pop, beat_last;
  logic [32:0] count_next;
  logic        fifo_full, fifo_empty;
  logic [DW:0] fifo_head;
  logic        unused_ok;

  assign CHNL_RX_CLK = CLK;

  // Offset is meaningless to this consumer and the last-transaction flag is
  // only kept for visibility, not control
  assign unused_ok = ^{CHNL_RX_OFF, r_last_txn};

  // 33-bit sum so a length near 2^32 cannot wrap the last-beat test
  assign count_next = {1'b0, r_count} + WPB33;
  assign beat_last  = (count_next >= {1'b0, r_len});

  // Full is a registered occupancy flag, so a same-cycle pop never frees a slot
  assign CHNL_RX_DATA_REN = (state == ST_RECV) && !fifo_full && (r_count < r_len);
  assign push             = CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID;
  assign pop              = STRM_VALID && STRM_READY;

  assign CHNL_RX_ACK = ack;
  assign BUSY        = busy;
  assign XFER_LEN    = r_len;
  assign STRM_VALID  = !fifo_empty;
  assign STRM_DATA   = fifo_head[DW-1:0];
  assign STRM_LAST   = fifo_head[DW];

  // Transaction FSM with registered ACK/BUSY outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      r_len      <= '0;
      r_count    <= '0;
      r_last_txn <= 1'b0;
      ack        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (CHNL_RX) begin
            r_len      <= CHNL_RX_LEN;
            r_count    <= '0;
            r_last_txn <= CHNL_RX_LAST;
            ack        <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_ACK;
          end
        end
        ST_ACK: begin
          state <= (r_len == '0) ? ST_DRAIN : ST_RECV;
        end
        ST_RECV: begin
          if (push) begin
            r_count <= count_next[31:0];
            if (beat_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  chnl_sync_fifo #(
    .WIDTH      (DW + 1),
    .DEPTH_LOG2 (C_FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .din   ({beat_last, CHNL_RX_DATA}),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
